e203_ifu_nxtpc_fetch: RTL and testbench
=======================================

# e203_ifu_nxtpc_fetch

Single-outstanding instruction fetch and next-PC sequencer for the E203 IFU. It issues fetch requests and captures each returned instruction. It presents the instruction to the mini-decoder and Lite-BPU, then holds it until the BPU stops waiting and the EXU accepts it into IR. It computes the next fetch PC from the BPU prediction operands, or from the EXU pipe-flush target.

## Interface
- RESET_PC, 32'h0000_1000, PC of the first fetch after reset
- clk  in  1  clock; one clock domain, reset is synchronous and active-high
- rst  in  1  synchronous active-high reset
- ifu_req_valid  out  1  fetch request valid
- ifu_req_ready  in  1  fetch request accepted
- ifu_req_pc  out  32  fetch address, bit0 always 0
- ifu_rsp_valid  in  1  fetch response valid
- ifu_rsp_ready  out  1  response accept
- ifu_rsp_instr  in  32  fetched instruction word
- ifu_rsp_err  in  1  bus error on fetch
- minidec_instr  out  32  held instruction to mini-decoder
- bpu_pc  out  32  PC of held instruction, to BPU
- dec_i_valid  out  1  held instruction valid to BPU
- bpu_wait  in  1  BPU dependency stall
- prdt_taken  in  1  BPU predicted taken
- prdt_pc_add_op1  in  32  next-PC adder operand 1
- prdt_pc_add_op2  in  32  next-PC adder operand 2
- ifu_o_valid  out  1  IR write valid
- ifu_o_ready  in  1  IR accepts
- ifu_o_ir  out  32  instruction
- ifu_o_pc  out  32  instruction PC
- ifu_o_prdt_taken  out  1  prediction carried to EXU
- ifu_o_buserr  out  1  fetch bus error carried to EXU
- pipe_flush_req  in  1  EXU redirect request
- pipe_flush_pc  in  32  redirect target
- pipe_flush_ack  out  1  redirect taken

## Operation
- States: REQ, RSP, DEC. Registers: fetch_pc, cur_pc, cur_instr, cur_err.
- REQ: ifu_req_valid = ~pipe_flush_req; ifu_req_pc = fetch_pc. On valid&ready: cur_pc <= fetch_pc, go RSP.
- RSP: ifu_rsp_ready = 1. On ifu_rsp_valid: cur_instr <= ifu_rsp_instr, cur_err <= ifu_rsp_err, go DEC.
- DEC: minidec_instr = cur_instr; bpu_pc = ifu_o_pc = cur_pc; dec_i_valid = ~cur_err.
  - ifu_o_valid = ~bpu_wait & ~pipe_flush_req.
  - On ifu_o_valid & ifu_o_ready, fetch_pc <= next PC and state goes to REQ.
- Next PC:
  - cur_err = 1: cur_pc + 4.
  - Otherwise, prdt_taken = 1: (op1 + op2) with bit0 forced to 0.
  - Otherwise: cur_pc + 4 when cur_instr[1:0] == 2'b11, else cur_pc + 2.
  - All sums are 32-bit modulo; carry is discarded, so 0xFFFF_FFFC + 4 gives 0.
- ifu_o_prdt_taken = prdt_taken & ~cur_err. ifu_o_buserr = cur_err. ifu_o_ir = cur_instr.
- Flush:
  - pipe_flush_ack = pipe_flush_req & (state != RSP | ifu_rsp_valid).
  - On ack: fetch_pc <= pipe_flush_pc with bit0 = 0, state goes to REQ.
  - Any held instruction or arriving response is discarded.
  - Flush has priority over IR handshake and over request issue in the same cycle.
  - In RSP without a response, the ack stalls until the response arrives; the outstanding response is always consumed, never orphaned.
- No new request is issued while a response is outstanding (single outstanding).

## Timing
- While rst = 1 and in the first cycle after: state = REQ, fetch_pc = RESET_PC, cur_* = 0.
- While rst = 1, all valid/ready/ack outputs are 0. The first ifu_req_valid is the cycle after rst falls.
- Request handshake at T leads to ifu_rsp_ready at T+1. A response at T+k puts DEC, dec_i_valid and ifu_o_valid at T+k+1 at the earliest.
- IR accept at cycle U leads to the next ifu_req_valid at U+1. Minimum of 3 cycles per instruction.
- bpu_wait must be sampled combinationally each DEC cycle. The held instruction and cur_pc stay stable across any number of wait cycles. This covers the BPU's regfile-read cycle: prediction operands are used only in the cycle IR accepts.
- ifu_o_* stay stable while ifu_o_valid = 1 and ifu_o_ready = 0.
- A flush acked at cycle F issues a request to the flush PC at F+1 (if no flush is pending then).
- Reset asserted mid-transaction: state returns to REQ. A later stray ifu_rsp_valid in REQ is ignored (ifu_rsp_ready = 0).

## Test plan
- Reset, RESET_PC = 0x1000, memory 0-wait: first request pc = 0x1000 the cycle after rst falls. Two sequential 32-bit ADDIs -> requests at 0x1000, 0x1004.
- Compressed 0x4501 at 0x1004 -> next request at 0x1006. A misaligned flush_pc 0x2003 -> request at 0x2002.
- Branch at 0x1010, prdt_taken = 1, op1 = 0x1010, op2 = 0xFFFFFFF0 -> next request at 0x1000, ifu_o_prdt_taken = 1.
- bpu_wait high for 3 DEC cycles with ifu_o_ready = 1 -> ifu_o_valid low 3 cycles, ir/pc stable. Accepted on 4th cycle using op1 sampled then.
- Flush in RSP with the response delayed 2 cycles -> ack coincides with rsp_valid, the instruction never reaches IR, and the next request goes to flush_pc.
- ifu_rsp_err = 1 at 0x1020 -> ifu_o_buserr = 1, dec_i_valid = 0, prdt ignored, next request at 0x1024.

Source files
------------

// File: rtl/e203_ifu_nxtpc_fetch.sv
// Single-outstanding instruction fetch and next-PC sequencer for the E203 IFU.
// Issues one fetch at a time and holds the returned instruction for the
// mini-decoder and Lite-BPU. The instruction is released into IR once the BPU
// stops waiting, and the next fetch PC then comes from the prediction operands.
// An EXU pipe flush redirects fetch to the flush target.
//
// state | meaning
// ------+-------------------------------------------------------------
// REQ   | presenting fetch request at fetch_pc
// RSP   | request accepted, waiting for the single outstanding response
// DEC   | holding cur_instr for mini-decoder/BPU until IR accepts it
module e203_ifu_nxtpc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ifu_req_valid,
    input  logic        ifu_req_ready,
    output logic [31:0] ifu_req_pc,
    input  logic        ifu_rsp_valid,
    output logic        ifu_rsp_ready,
    input  logic [31:0] ifu_rsp_instr,
    input  logic        ifu_rsp_err,
    output logic [31:0] minidec_instr,
    output logic [31:0] bpu_pc,
    output logic        dec_i_valid,
    input  logic        bpu_wait,
    input  logic        prdt_taken,
    input  logic [31:0] prdt_pc_add_op1,
    input  logic [31:0] prdt_pc_add_op2,
    output logic        ifu_o_valid,
    input  logic        ifu_o_ready,
    output logic [31:0] ifu_o_ir,
    output logic [31:0] ifu_o_pc,
    output logic        ifu_o_prdt_taken,
    output logic        ifu_o_buserr,
    input  logic        pipe_flush_req,
    input  logic [31:0] pipe_flush_pc,
    output logic        pipe_flush_ack
);

    typedef enum logic [1:0] {
        ST_REQ = 2'd0,
        ST_RSP = 2'd1,
        ST_DEC = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] fetch_pc;
    logic [31:0] cur_pc;
    logic [31:0] cur_instr;
    logic        cur_err;
    logic [31:0] prdt_sum;
    logic [31:0] nxt_pc;
    logic        in_req;
    logic        in_rsp;
    logic        in_dec;

    // Handshake outputs are decoded from the registered state and masked while
    // in reset so nothing leaks out before the state register settles.
    always_comb begin
        in_req           = (state == ST_REQ);
        in_rsp           = (state == ST_RSP);
        in_dec           = (state == ST_DEC);
        ifu_req_valid    = ~rst & in_req & ~pipe_flush_req;
        ifu_req_pc       = fetch_pc;
        ifu_rsp_ready    = ~rst & in_rsp;
        minidec_instr    = cur_instr;
        bpu_pc           = cur_pc;
        dec_i_valid      = ~rst & in_dec & ~cur_err;
        ifu_o_valid      = ~rst & in_dec & ~bpu_wait & ~pipe_flush_req;
        ifu_o_ir         = cur_instr;
        ifu_o_pc         = cur_pc;
        ifu_o_prdt_taken = prdt_taken & ~cur_err;
        ifu_o_buserr     = cur_err;
        // An outstanding response must be consumed before the redirect is taken.
        pipe_flush_ack   = ~rst & pipe_flush_req & (~in_rsp | ifu_rsp_valid);
    end

    // Next-PC select; a faulted fetch ignores the prediction and steps by 4.
    always_comb begin
        prdt_sum = prdt_pc_add_op1 + prdt_pc_add_op2;
        if (cur_err) begin
            nxt_pc = cur_pc + 32'd4;
        end else if (prdt_taken) begin
            nxt_pc = {prdt_sum[31:1], 1'b0};
        end else if (cur_instr[1:0] == 2'b11) begin
            nxt_pc = cur_pc + 32'd4;
        end else begin
            nxt_pc = cur_pc + 32'd2;
        end
    end

    // Fetch FSM; a flush ack overrides both the IR handshake and request issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_REQ;
            fetch_pc  <= RESET_PC;
            cur_pc    <= 32'd0;
            cur_instr <= 32'd0;
            cur_err   <= 1'b0;
        end else if (pipe_flush_ack) begin
            fetch_pc <= {pipe_flush_pc[31:1], 1'b0};
            state    <= ST_REQ;
        end else begin
            case (state)
                ST_REQ: begin
                    if (ifu_req_valid && ifu_req_ready) begin
                        cur_pc <= fetch_pc;
                        state  <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (ifu_rsp_valid) begin
                        cur_instr <= ifu_rsp_instr;
                        cur_err   <= ifu_rsp_err;
                        state     <= ST_DEC;
                    end
                end
                ST_DEC: begin
                    if (ifu_o_valid && ifu_o_ready) begin
                        fetch_pc <= nxt_pc;
                        state    <= ST_REQ;
                    end
                end
                default: state <= ST_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_e203_ifu_nxtpc_fetch.sv
// Directed bench for e203_ifu_nxtpc_fetch: sequential, compressed, predicted
// branch, BPU wait, IR stall, flushes in DEC/RSP/REQ, bus error, PC wrap and
// mid-transaction reset.
module tb_e203_ifu_nxtpc_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_req_pc;
    logic        ifu_rsp_valid;
    logic        ifu_rsp_ready;
    logic [31:0] ifu_rsp_instr;
    logic        ifu_rsp_err;
    logic [31:0] minidec_instr;
    logic [31:0] bpu_pc;
    logic        dec_i_valid;
    logic        bpu_wait;
    logic        prdt_taken;
    logic [31:0] prdt_pc_add_op1;
    logic [31:0] prdt_pc_add_op2;
    logic        ifu_o_valid;
    logic        ifu_o_ready;
    logic [31:0] ifu_o_ir;
    logic [31:0] ifu_o_pc;
    logic        ifu_o_prdt_taken;
    logic        ifu_o_buserr;
    logic        pipe_flush_req;
    logic [31:0] pipe_flush_pc;
    logic        pipe_flush_ack;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    e203_ifu_nxtpc_fetch #(.RESET_PC(32'h0000_1000)) dut (
        .clk              (clk),
        .rst              (rst),
        .ifu_req_valid    (ifu_req_valid),
        .ifu_req_ready    (ifu_req_ready),
        .ifu_req_pc       (ifu_req_pc),
        .ifu_rsp_valid    (ifu_rsp_valid),
        .ifu_rsp_ready    (ifu_rsp_ready),
        .ifu_rsp_instr    (ifu_rsp_instr),
        .ifu_rsp_err      (ifu_rsp_err),
        .minidec_instr    (minidec_instr),
        .bpu_pc           (bpu_pc),
        .dec_i_valid      (dec_i_valid),
        .bpu_wait         (bpu_wait),
        .prdt_taken       (prdt_taken),
        .prdt_pc_add_op1  (prdt_pc_add_op1),
        .prdt_pc_add_op2  (prdt_pc_add_op2),
        .ifu_o_valid      (ifu_o_valid),
        .ifu_o_ready      (ifu_o_ready),
        .ifu_o_ir         (ifu_o_ir),
        .ifu_o_pc         (ifu_o_pc),
        .ifu_o_prdt_taken (ifu_o_prdt_taken),
        .ifu_o_buserr     (ifu_o_buserr),
        .pipe_flush_req   (pipe_flush_req),
        .pipe_flush_pc    (pipe_flush_pc),
        .pipe_flush_ack   (pipe_flush_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] ev);
        n_total++;
        assert (obs === ev) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, ev);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic ev);
        n_total++;
        assert (obs === ev) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, ev);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Check the request in REQ, handshake it, and confirm the RSP state.
    task automatic do_req(input logic [31:0] pc);
        settle();
        chk1("req_valid", ifu_req_valid, 1'b1);
        chk("req_pc", ifu_req_pc, pc);
        chk1("req_rsp_ready", ifu_rsp_ready, 1'b0);
        ifu_req_ready = 1'b1;
        step();
        ifu_req_ready = 1'b0;
        settle();
        chk1("rsp_ready", ifu_rsp_ready, 1'b1);
        chk1("single_outstanding", ifu_req_valid, 1'b0);
    endtask

    task automatic do_rsp(input logic [31:0] instr, input logic err, input int dly);
        for (int i = 0; i < dly; i++) begin
            step();
            settle();
            chk1("rsp_wait_ovalid", ifu_o_valid, 1'b0);
        end
        ifu_rsp_valid = 1'b1;
        ifu_rsp_instr = instr;
        ifu_rsp_err   = err;
        step();
        ifu_rsp_valid = 1'b0;
        ifu_rsp_err   = 1'b0;
        settle();
    endtask

    // In DEC: check the held instruction and accept it into IR.
    task automatic do_acc(input logic [31:0] pc, input logic [31:0] ir, input logic err,
                          input logic taken, input logic [31:0] op1, input logic [31:0] op2);
        prdt_taken      = taken;
        prdt_pc_add_op1 = op1;
        prdt_pc_add_op2 = op2;
        ifu_o_ready     = 1'b1;
        settle();
        chk1("o_valid", ifu_o_valid, 1'b1);
        chk("o_pc", ifu_o_pc, pc);
        chk("o_ir", ifu_o_ir, ir);
        chk("bpu_pc", bpu_pc, pc);
        chk("minidec", minidec_instr, ir);
        chk1("o_buserr", ifu_o_buserr, err);
        chk1("dec_i_valid", dec_i_valid, ~err);
        chk1("o_prdt_taken", ifu_o_prdt_taken, taken & ~err);
        step();
        ifu_o_ready     = 1'b0;
        prdt_taken      = 1'b0;
        prdt_pc_add_op1 = 32'd0;
        prdt_pc_add_op2 = 32'd0;
    endtask

    initial begin
        rst             = 1'b1;
        ifu_req_ready   = 1'b0;
        ifu_rsp_valid   = 1'b0;
        ifu_rsp_instr   = 32'd0;
        ifu_rsp_err     = 1'b0;
        bpu_wait        = 1'b0;
        prdt_taken      = 1'b0;
        prdt_pc_add_op1 = 32'd0;
        prdt_pc_add_op2 = 32'd0;
        ifu_o_ready     = 1'b0;
        pipe_flush_req  = 1'b0;
        pipe_flush_pc   = 32'd0;

        // Reset: every valid/ready/ack output low, even with a flush request.
        step();
        step();
        settle();
        chk1("rst_req_valid", ifu_req_valid, 1'b0);
        chk1("rst_rsp_ready", ifu_rsp_ready, 1'b0);
        chk1("rst_o_valid", ifu_o_valid, 1'b0);
        chk1("rst_dec_valid", dec_i_valid, 1'b0);
        chk("rst_req_pc", ifu_req_pc, 32'h0000_1000);
        chk("rst_cur_pc", ifu_o_pc, 32'h0);
        chk("rst_cur_ir", ifu_o_ir, 32'h0);
        pipe_flush_req = 1'b1;
        settle();
        chk1("rst_flush_ack", pipe_flush_ack, 1'b0);
        pipe_flush_req = 1'b0;
        rst = 1'b0;

        // 32-bit ADDI at 0x1000 -> 0x1004; compressed at 0x1004 -> 0x1006.
        do_req(32'h0000_1000);
        do_rsp(32'h0010_0093, 1'b0, 0);
        do_acc(32'h0000_1000, 32'h0010_0093, 1'b0, 1'b0, 32'd0, 32'd0);
        do_req(32'h0000_1004);
        do_rsp(32'h0000_4501, 1'b0, 0);
        do_acc(32'h0000_1004, 32'h0000_4501, 1'b0, 1'b0, 32'd0, 32'd0);

        // BPU wait for 3 DEC cycles; operands change during the wait, only
        // those present at accept count: 0x1010 + 0 -> 0x1010.
        do_req(32'h0000_1006);
        do_rsp(32'h0000_0513, 1'b0, 1);
        bpu_wait        = 1'b1;
        ifu_o_ready     = 1'b1;
        prdt_taken      = 1'b1;
        prdt_pc_add_op1 = 32'hDEAD_0000;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk1("wait_o_valid", ifu_o_valid, 1'b0);
            chk1("wait_dec_valid", dec_i_valid, 1'b1);
            chk("wait_o_pc", ifu_o_pc, 32'h0000_1006);
            chk("wait_minidec", minidec_instr, 32'h0000_0513);
            step();
        end
        bpu_wait    = 1'b0;
        ifu_o_ready = 1'b0;
        do_acc(32'h0000_1006, 32'h0000_0513, 1'b0, 1'b1, 32'h0000_1010, 32'h0);

        // Predicted-taken branch: 0x1010 + 0xFFFFFFF0 -> 0x1000.
        do_req(32'h0000_1010);
        do_rsp(32'hFE00_0AE3, 1'b0, 0);
        do_acc(32'h0000_1010, 32'hFE00_0AE3, 1'b0, 1'b1, 32'h0000_1010, 32'hFFFF_FFF0);

        // IR stall keeps outputs stable, then a flush in DEC wins over accept.
        do_req(32'h0000_1000);
        do_rsp(32'h0000_0013, 1'b0, 0);
        settle();
        chk1("stall_o_valid", ifu_o_valid, 1'b1);
        step();
        settle();
        chk1("stall_o_valid2", ifu_o_valid, 1'b1);
        chk("stall_o_ir", ifu_o_ir, 32'h0000_0013);
        chk("stall_o_pc", ifu_o_pc, 32'h0000_1000);
        pipe_flush_req = 1'b1;
        pipe_flush_pc  = 32'h0000_2003;
        ifu_o_ready    = 1'b1;
        settle();
        chk1("dec_flush_ack", pipe_flush_ack, 1'b1);
        chk1("dec_flush_ovalid", ifu_o_valid, 1'b0);
        step();
        pipe_flush_req = 1'b0;
        ifu_o_ready    = 1'b0;
        do_req(32'h0000_2002);

        // Flush in RSP with the response 2 cycles late: ack waits for it.
        pipe_flush_req = 1'b1;
        pipe_flush_pc  = 32'h0000_1020;
        settle();
        chk1("rsp_flush_ack0", pipe_flush_ack, 1'b0);
        step();
        settle();
        chk1("rsp_flush_ack1", pipe_flush_ack, 1'b0);
        step();
        ifu_rsp_valid = 1'b1;
        ifu_rsp_instr = 32'h00A0_0093;
        settle();
        chk1("rsp_flush_ack2", pipe_flush_ack, 1'b1);
        chk1("rsp_flush_rdy", ifu_rsp_ready, 1'b1);
        step();
        ifu_rsp_valid  = 1'b0;
        pipe_flush_req = 1'b0;
        settle();
        chk1("rsp_flush_ovalid", ifu_o_valid, 1'b0);

        // Bus error: prediction ignored, next PC = 0x1020 + 4.
        do_req(32'h0000_1020);
        do_rsp(32'h1234_5677, 1'b1, 0);
        do_acc(32'h0000_1020, 32'h1234_5677, 1'b1, 1'b1, 32'h0000_5000, 32'h4);

        // Flush in REQ suppresses the request; then wrap 0xFFFFFFFC + 4 -> 0.
        settle();
        chk1("err_next_valid", ifu_req_valid, 1'b1);
        chk("err_next_pc", ifu_req_pc, 32'h0000_1024);
        pipe_flush_req = 1'b1;
        pipe_flush_pc  = 32'hFFFF_FFFC;
        settle();
        chk1("req_flush_reqv", ifu_req_valid, 1'b0);
        chk1("req_flush_ack", pipe_flush_ack, 1'b1);
        step();
        pipe_flush_req = 1'b0;
        do_req(32'hFFFF_FFFC);
        do_rsp(32'h0000_0013, 1'b0, 0);
        do_acc(32'hFFFF_FFFC, 32'h0000_0013, 1'b0, 1'b0, 32'd0, 32'd0);
        do_req(32'h0000_0000);

        // Reset mid-transaction (in RSP); a stray response afterwards is ignored.
        rst = 1'b1;
        settle();
        chk1("mid_rst_rsp_ready", ifu_rsp_ready, 1'b0);
        step();
        rst           = 1'b0;
        ifu_rsp_valid = 1'b1;
        settle();
        chk1("stray_rsp_ready", ifu_rsp_ready, 1'b0);
        chk1("stray_req_valid", ifu_req_valid, 1'b1);
        chk("stray_req_pc", ifu_req_pc, 32'h0000_1000);
        chk1("stray_o_valid", ifu_o_valid, 1'b0);
        step();
        ifu_rsp_valid = 1'b0;
        settle();
        chk1("stray_still_req", ifu_req_valid, 1'b1);
        chk("stray_still_pc", ifu_req_pc, 32'h0000_1000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
